// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//   DEFAULT_WIDTH : default operand/sum width in bits
//   state_t       : FSM state encoding (ST_IDLE = 0, ST_RUN = 1)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Start/busy/done handshake and operand/result bus of the serial adder.
//   start : request, sampled only while busy = 0
//   a, b  : WIDTH-bit operands, sampled with start
//   cin   : carry-in, sampled with start
//   busy  : addition in progress
//   done  : one-cycle pulse, sum/cout just updated
//   sum   : registered WIDTH-bit result of the last completed addition
//   cout  : registered carry-out of the last completed addition
// Modports: master = controller side, slave = adder side.
// -----------------------------------------------------------------------------
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder, the bit cell of the serial adder.
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial ripple adder: {cout, sum} = a + b + cin, LSB first, one bit per
// clock through one full-adder cell and a carry flop. Result appears WIDTH+1
// edges after start is sampled; all outputs are registered.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt;

    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;
    logic             load;
    logic             shift;
    logic             finish;

    full_adder u_cell (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .c     (carry_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: defaulting every always_comb output first keeps it latch-free.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_bit)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath control decode. start is only honoured in IDLE, so a request
    // raised while busy never reloads the operands.
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        case (state)
            ST_IDLE: load = bus.start;
            ST_RUN: begin
                shift  = 1'b1;
                finish = last_bit;
            end
            default: ;
        endcase
    end

    // Datapath. Each RUN edge consumes the operand LSBs and pushes the sum
    // bit in at the MSB end, so after WIDTH shifts bit 0 sits at psum[0].
    // The final bit goes straight into sum_q so the result lands on the
    // completing edge without an extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            psum    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                op_a    <= bus.a;
                op_b    <= bus.b;
                carry_q <= bus.cin;
                cnt     <= '0;
                psum    <= '0;
            end else if (shift) begin
                op_a    <= op_a >> 1;
                op_b    <= op_b >> 1;
                carry_q <= cell_carry;
                cnt     <= cnt + CNT_W'(1);
                psum    <= {cell_sum, psum[WIDTH-1:1]};
            end
            if (finish) begin
                sum_q  <= {cell_sum, psum[WIDTH-1:1]};
                cout_q <= cell_carry;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
